// File: rtl/sdram_axi_arbiter.sv
// Two-master AXI arbiter in front of the sdram controller's single AXI slave port.
// One whole transaction (address + counted data beats) per grant; round-robin unless SDRAM_ARB_FIXED_PRIO_EN.
module sdram_axi_arbiter #(
    parameter int AW = 22,
    parameter int DW = 16,
    parameter int LW = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [AW-1:0]     m0_axi_awaddr,
    input  logic [LW-1:0]     m0_axi_awlen,
    input  logic [2:0]        m0_axi_awsize,
    input  logic [1:0]        m0_axi_awburst,
    input  logic              m0_axi_awvalid,
    output logic              m0_axi_awready,
    input  logic [AW-1:0]     m0_axi_araddr,
    input  logic [LW-1:0]     m0_axi_arlen,
    input  logic [2:0]        m0_axi_arsize,
    input  logic [1:0]        m0_axi_arburst,
    input  logic              m0_axi_arvalid,
    output logic              m0_axi_arready,
    input  logic [DW-1:0]     m0_axi_wdata,
    input  logic [DW/8-1:0]   m0_axi_wstrb,
    input  logic              m0_axi_wvalid,
    output logic              m0_axi_wready,
    output logic [DW-1:0]     m0_axi_rdata,
    output logic              m0_axi_rvalid,
    input  logic              m0_axi_rready,

    input  logic [AW-1:0]     m1_axi_awaddr,
    input  logic [LW-1:0]     m1_axi_awlen,
    input  logic [2:0]        m1_axi_awsize,
    input  logic [1:0]        m1_axi_awburst,
    input  logic              m1_axi_awvalid,
    output logic              m1_axi_awready,
    input  logic [AW-1:0]     m1_axi_araddr,
    input  logic [LW-1:0]     m1_axi_arlen,
    input  logic [2:0]        m1_axi_arsize,
    input  logic [1:0]        m1_axi_arburst,
    input  logic              m1_axi_arvalid,
    output logic              m1_axi_arready,
    input  logic [DW-1:0]     m1_axi_wdata,
    input  logic [DW/8-1:0]   m1_axi_wstrb,
    input  logic              m1_axi_wvalid,
    output logic              m1_axi_wready,
    output logic [DW-1:0]     m1_axi_rdata,
    output logic              m1_axi_rvalid,
    input  logic              m1_axi_rready,

    output logic [AW-1:0]     s_axi_awaddr,
    output logic [LW-1:0]     s_axi_awlen,
    output logic [2:0]        s_axi_awsize,
    output logic [1:0]        s_axi_awburst,
    output logic              s_axi_awvalid,
    input  logic              s_axi_awready,
    output logic [AW-1:0]     s_axi_araddr,
    output logic [LW-1:0]     s_axi_arlen,
    output logic [2:0]        s_axi_arsize,
    output logic [1:0]        s_axi_arburst,
    output logic              s_axi_arvalid,
    input  logic              s_axi_arready,
    output logic [DW-1:0]     s_axi_wdata,
    output logic [DW/8-1:0]   s_axi_wstrb,
    output logic              s_axi_wvalid,
    input  logic              s_axi_wready,
    input  logic [DW-1:0]     s_axi_rdata,
    input  logic              s_axi_rvalid,
    output logic              s_axi_rready,

    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, WA, WD, RA, RD} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            ptr_q, ptr_d;
    logic [LW-1:0]   cnt_q, cnt_d;

    logic [AW-1:0]   awaddr_a  [2];
    logic [LW-1:0]   awlen_a   [2];
    logic [2:0]      awsize_a  [2];
    logic [1:0]      awburst_a [2];
    logic            awvalid_a [2];
    logic [AW-1:0]   araddr_a  [2];
    logic [LW-1:0]   arlen_a   [2];
    logic [2:0]      arsize_a  [2];
    logic [1:0]      arburst_a [2];
    logic            arvalid_a [2];
    logic [DW-1:0]   wdata_a   [2];
    logic [DW/8-1:0] wstrb_a   [2];
    logic            wvalid_a  [2];
    logic            rready_a  [2];

    logic            awready_a [2];
    logic            arready_a [2];
    logic            wready_a  [2];
    logic            rvalid_a  [2];

    logic [1:0]      req;
    logic            sel;
    logic            next_ptr;
    logic            aw_hs, w_hs, ar_hs, r_hs;

    assign awaddr_a[0]  = m0_axi_awaddr;   assign awaddr_a[1]  = m1_axi_awaddr;
    assign awlen_a[0]   = m0_axi_awlen;    assign awlen_a[1]   = m1_axi_awlen;
    assign awsize_a[0]  = m0_axi_awsize;   assign awsize_a[1]  = m1_axi_awsize;
    assign awburst_a[0] = m0_axi_awburst;  assign awburst_a[1] = m1_axi_awburst;
    assign awvalid_a[0] = m0_axi_awvalid;  assign awvalid_a[1] = m1_axi_awvalid;
    assign araddr_a[0]  = m0_axi_araddr;   assign araddr_a[1]  = m1_axi_araddr;
    assign arlen_a[0]   = m0_axi_arlen;    assign arlen_a[1]   = m1_axi_arlen;
    assign arsize_a[0]  = m0_axi_arsize;   assign arsize_a[1]  = m1_axi_arsize;
    assign arburst_a[0] = m0_axi_arburst;  assign arburst_a[1] = m1_axi_arburst;
    assign arvalid_a[0] = m0_axi_arvalid;  assign arvalid_a[1] = m1_axi_arvalid;
    assign wdata_a[0]   = m0_axi_wdata;    assign wdata_a[1]   = m1_axi_wdata;
    assign wstrb_a[0]   = m0_axi_wstrb;    assign wstrb_a[1]   = m1_axi_wstrb;
    assign wvalid_a[0]  = m0_axi_wvalid;   assign wvalid_a[1]  = m1_axi_wvalid;
    assign rready_a[0]  = m0_axi_rready;   assign rready_a[1]  = m1_axi_rready;

    assign m0_axi_awready = awready_a[0];  assign m1_axi_awready = awready_a[1];
    assign m0_axi_arready = arready_a[0];  assign m1_axi_arready = arready_a[1];
    assign m0_axi_wready  = wready_a[0];   assign m1_axi_wready  = wready_a[1];
    assign m0_axi_rvalid  = rvalid_a[0];   assign m1_axi_rvalid  = rvalid_a[1];

    // Read data is shared; rvalid alone tells each master whether a beat is theirs.
    assign m0_axi_rdata = s_axi_rdata;
    assign m1_axi_rdata = s_axi_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic own;
            assign own           = (owner_q == 1'(gi));
            assign req[gi]       = awvalid_a[gi] | arvalid_a[gi];
            assign awready_a[gi] = own && (state_q == WA) && s_axi_awready;
            assign wready_a[gi]  = own && (state_q == WD) && s_axi_wready;
            assign arready_a[gi] = own && (state_q == RA) && s_axi_arready;
            assign rvalid_a[gi]  = own && (state_q == RD) && s_axi_rvalid;
        end
    endgenerate

    assign busy  = (state_q != IDLE);
    assign grant = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    // Address/data fields are zeroed while idle so nothing stale reaches the controller.
    assign s_axi_awaddr  = busy ? awaddr_a[owner_q]  : '0;
    assign s_axi_awlen   = busy ? awlen_a[owner_q]   : '0;
    assign s_axi_awsize  = busy ? awsize_a[owner_q]  : '0;
    assign s_axi_awburst = busy ? awburst_a[owner_q] : '0;
    assign s_axi_araddr  = busy ? araddr_a[owner_q]  : '0;
    assign s_axi_arlen   = busy ? arlen_a[owner_q]   : '0;
    assign s_axi_arsize  = busy ? arsize_a[owner_q]  : '0;
    assign s_axi_arburst = busy ? arburst_a[owner_q] : '0;
    assign s_axi_wdata   = busy ? wdata_a[owner_q]   : '0;
    assign s_axi_wstrb   = busy ? wstrb_a[owner_q]   : '0;

    assign s_axi_awvalid = (state_q == WA) && awvalid_a[owner_q];
    assign s_axi_wvalid  = (state_q == WD) && wvalid_a[owner_q];
    assign s_axi_arvalid = (state_q == RA) && arvalid_a[owner_q];
    assign s_axi_rready  = (state_q == RD) && rready_a[owner_q];

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid  & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign r_hs  = s_axi_rvalid  & s_axi_rready;

    assign sel = (req == 2'b11) ? ptr_q : ~req[0];

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign next_ptr = 1'b0;
`else
    assign next_ptr = ~owner_q;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = sel;
                    state_d = awvalid_a[sel] ? WA : RA;
                end
            end
            WA: begin
                if (aw_hs) begin
                    cnt_d   = awlen_a[owner_q];
                    state_d = WD;
                end
            end
            WD: begin
                if (w_hs) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        ptr_d   = next_ptr;
                    end else begin
                        cnt_d = cnt_q - LW'(1);
                    end
                end
            end
            RA: begin
                if (ar_hs) begin
                    cnt_d   = arlen_a[owner_q];
                    state_d = RD;
                end
            end
            RD: begin
                if (r_hs) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        ptr_d   = next_ptr;
                    end else begin
                        cnt_d = cnt_q - LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sdram_axi_arbiter.sv
// Directed bench for sdram_axi_arbiter with a small behavioural AXI slave (memory) on the slave port.
module tb_sdram_axi_arbiter;

    localparam int AW  = 22;
    localparam int DW  = 16;
    localparam int LW  = 8;
    localparam int TMO = 2000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [AW-1:0] m_awaddr [2];
    logic [LW-1:0] m_awlen  [2];
    logic [2:0]    m_awsize [2];
    logic [1:0]    m_awburst[2];
    logic          m_awvalid[2];
    logic [AW-1:0] m_araddr [2];
    logic [LW-1:0] m_arlen  [2];
    logic [2:0]    m_arsize [2];
    logic [1:0]    m_arburst[2];
    logic          m_arvalid[2];
    logic [DW-1:0] m_wdata  [2];
    logic [1:0]    m_wstrb  [2];
    logic          m_wvalid [2];
    logic          m_rready [2];
    wire           m_awready[2];
    wire           m_arready[2];
    wire           m_wready [2];
    wire           m_rvalid [2];
    wire  [DW-1:0] m_rdata  [2];

    wire  [AW-1:0] s_awaddr, s_araddr;
    wire  [LW-1:0] s_awlen, s_arlen;
    wire  [2:0]    s_awsize, s_arsize;
    wire  [1:0]    s_awburst, s_arburst, s_wstrb;
    wire           s_awvalid, s_arvalid, s_wvalid, s_rready;
    wire  [DW-1:0] s_wdata;
    logic          s_wready;
    logic          s_rvalid;
    logic [DW-1:0] s_rdata;
    wire  [1:0]    grant;
    wire           busy;

    sdram_axi_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .reset(reset),
        .m0_axi_awaddr(m_awaddr[0]), .m0_axi_awlen(m_awlen[0]), .m0_axi_awsize(m_awsize[0]),
        .m0_axi_awburst(m_awburst[0]), .m0_axi_awvalid(m_awvalid[0]), .m0_axi_awready(m_awready[0]),
        .m0_axi_araddr(m_araddr[0]), .m0_axi_arlen(m_arlen[0]), .m0_axi_arsize(m_arsize[0]),
        .m0_axi_arburst(m_arburst[0]), .m0_axi_arvalid(m_arvalid[0]), .m0_axi_arready(m_arready[0]),
        .m0_axi_wdata(m_wdata[0]), .m0_axi_wstrb(m_wstrb[0]), .m0_axi_wvalid(m_wvalid[0]),
        .m0_axi_wready(m_wready[0]), .m0_axi_rdata(m_rdata[0]), .m0_axi_rvalid(m_rvalid[0]),
        .m0_axi_rready(m_rready[0]),
        .m1_axi_awaddr(m_awaddr[1]), .m1_axi_awlen(m_awlen[1]), .m1_axi_awsize(m_awsize[1]),
        .m1_axi_awburst(m_awburst[1]), .m1_axi_awvalid(m_awvalid[1]), .m1_axi_awready(m_awready[1]),
        .m1_axi_araddr(m_araddr[1]), .m1_axi_arlen(m_arlen[1]), .m1_axi_arsize(m_arsize[1]),
        .m1_axi_arburst(m_arburst[1]), .m1_axi_arvalid(m_arvalid[1]), .m1_axi_arready(m_arready[1]),
        .m1_axi_wdata(m_wdata[1]), .m1_axi_wstrb(m_wstrb[1]), .m1_axi_wvalid(m_wvalid[1]),
        .m1_axi_wready(m_wready[1]), .m1_axi_rdata(m_rdata[1]), .m1_axi_rvalid(m_rvalid[1]),
        .m1_axi_rready(m_rready[1]),
        .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awsize(s_awsize),
        .s_axi_awburst(s_awburst), .s_axi_awvalid(s_awvalid), .s_axi_awready(1'b1),
        .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize),
        .s_axi_arburst(s_arburst), .s_axi_arvalid(s_arvalid), .s_axi_arready(1'b1),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wvalid(s_wvalid),
        .s_axi_wready(s_wready), .s_axi_rdata(s_rdata), .s_axi_rvalid(s_rvalid),
        .s_axi_rready(s_rready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural slave ----------------
    logic [DW-1:0] mem [4096];
    logic [11:0]   w_addr, r_addr;
    logic [7:0]    w_beat, r_beat, r_len;
    logic          r_active;
    logic          wmode = 1'b0;
    int            cyc = 0;
    int            wbeats = 0;
    int            lastw_cyc = 0;
    int            ar_cyc = 0;
    logic [AW-1:0] rec_awaddr, rec_araddr;
    logic [LW-1:0] rec_awlen;
    logic [2:0]    rec_awsize, rec_arsize;
    logic [1:0]    rec_awburst, rec_arburst, rec_wstrb;

    assign s_wready = wmode ? (cyc % 3 != 2) : 1'b1;
    assign s_rvalid = r_active;
    assign s_rdata  = r_active ? mem[r_addr + {4'b0, r_beat}] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr   <= '0;
            w_beat   <= '0;
            r_addr   <= '0;
            r_beat   <= '0;
            r_len    <= '0;
            r_active <= 1'b0;
        end else begin
            if (s_awvalid) begin
                w_addr <= s_awaddr[11:0];
                w_beat <= '0;
            end
            if (s_wvalid && s_wready) w_beat <= w_beat + 8'd1;
            if (s_arvalid) begin
                r_addr   <= s_araddr[11:0];
                r_len    <= s_arlen;
                r_beat   <= '0;
                r_active <= 1'b1;
            end
            if (s_rvalid && s_rready) begin
                r_beat <= r_beat + 8'd1;
                if (r_beat == r_len) r_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_wvalid && s_wready) begin
            mem[w_addr + {4'b0, w_beat}] <= s_wdata;
            wbeats    <= wbeats + 1;
            lastw_cyc <= cyc;
            rec_wstrb <= s_wstrb;
        end
        if (s_awvalid) begin
            rec_awaddr  <= s_awaddr;
            rec_awlen   <= s_awlen;
            rec_awsize  <= s_awsize;
            rec_awburst <= s_awburst;
        end
        if (s_arvalid) begin
            ar_cyc      <= cyc;
            rec_araddr  <= s_araddr;
            rec_arsize  <= s_arsize;
            rec_arburst <= s_arburst;
        end
    end

    // ---------------- monitor ----------------
    logic [1:0] gseq [64];
    int         gn = 0;
    logic [1:0] prev_grant = 2'b00;
    int         busy_cnt = 0;
    int         v0 = 0;

    always_ff @(negedge clk) begin
        prev_grant <= grant;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (grant != 2'b00 && prev_grant == 2'b00 && gn < 64) begin
            gseq[gn] <= grant;
            gn       <= gn + 1;
        end
        if (grant == 2'b10 && (m_awready[0] || m_wready[0] || m_arready[0] || m_rvalid[0]))
            v0 <= v0 + 1;
    end

    // ---------------- checking helpers ----------------
    int compared   = 0;
    int mismatched = 0;
    logic [DW-1:0] rd_buf [2][256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_write(input int k, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [DW-1:0] base);
        int t;
        @(posedge clk); #1;
        m_awaddr[k]  = addr;
        m_awlen[k]   = len;
        m_awvalid[k] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!m_awready[k] && t < TMO);
        if (!m_awready[k]) begin
            check("aw_timeout", 32'(m_awready[k]), 32'd1);
            m_awvalid[k] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        m_awvalid[k] = 1'b0;
        m_wvalid[k]  = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            m_wdata[k] = base + DW'(b);
            t = 0;
            do begin @(negedge clk); t++; end while (!m_wready[k] && t < TMO);
            if (!m_wready[k]) begin
                check("w_timeout", 32'(m_wready[k]), 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        m_wvalid[k] = 1'b0;
        $display("write m%0d addr=%06h len=%0d base=%04h", k, addr, len, base);
    endtask

    task automatic m_read(input int k, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int t;
        @(posedge clk); #1;
        m_araddr[k]  = addr;
        m_arlen[k]   = len;
        m_arvalid[k] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!m_arready[k] && t < TMO);
        if (!m_arready[k]) begin
            check("ar_timeout", 32'(m_arready[k]), 32'd1);
            m_arvalid[k] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        m_arvalid[k] = 1'b0;
        m_rready[k]  = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!m_rvalid[k] && t < TMO);
            if (!m_rvalid[k]) begin
                check("r_timeout", 32'(m_rvalid[k]), 32'd1);
                break;
            end
            rd_buf[k][b] = m_rdata[k];
            @(posedge clk); #1;
        end
        m_rready[k] = 1'b0;
        $display("read  m%0d addr=%06h len=%0d first=%04h", k, addr, len, rd_buf[k][0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int b0, g0, w0, v_0, t, nb;
        logic [1:0] first_b, second_b;

        for (int k = 0; k < 2; k++) begin
            m_awaddr[k] = '0; m_awlen[k] = '0; m_awsize[k] = 3'b001; m_awburst[k] = 2'b01;
            m_awvalid[k] = 1'b0;
            m_araddr[k] = '0; m_arlen[k] = '0; m_arsize[k] = 3'b001; m_arburst[k] = 2'b01;
            m_arvalid[k] = 1'b0;
            m_wdata[k] = '0; m_wstrb[k] = 2'b11; m_wvalid[k] = 1'b0; m_rready[k] = 1'b0;
        end

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant",   32'(grant), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_awvalid", 32'(s_awvalid), 32'd0);
        check("rst_arvalid", 32'(s_arvalid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single write then read-back by m0
        b0 = busy_cnt;
        m_write(0, 22'h000000, 8'd0, 16'h1234);
        check("t1_w_busycyc", 32'(busy_cnt - b0), 32'd2);
        check("t1_w_grant",   32'(gseq[gn-1]), 32'd1);
        check("t1_idle_grant", 32'(grant), 32'd0);
        check("t1_mem0",      32'(mem[0]), 32'h1234);
        check("t1_awsize",    32'(rec_awsize), 32'd1);
        check("t1_awburst",   32'(rec_awburst), 32'd1);
        check("t1_wstrb",     32'(rec_wstrb), 32'd3);
        b0 = busy_cnt;
        m_read(0, 22'h000000, 8'd0);
        check("t1_rdata",     32'(rd_buf[0][0]), 32'h1234);
        check("t1_r_busycyc", 32'(busy_cnt - b0), 32'd2);
        check("t1_r_grant",   32'(gseq[gn-1]), 32'd1);
        check("t1_grant_starts", 32'(gn), 32'd2);
        check("t1_arsize",    32'(rec_arsize), 32'd1);
        check("t1_arburst",   32'(rec_arburst), 32'd1);

        // fresh reset so ptr starts at 0, then simultaneous requests
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        g0 = gn;
        b0 = busy_cnt;
        fork
            m_write(0, 22'h000000, 8'd3, 16'h1000);
            m_write(1, 22'h000100, 8'd3, 16'h2000);
        join
        check("t2_first",   32'(gseq[g0]), 32'd1);
        check("t2_second",  32'(gseq[g0+1]), 32'd2);
        check("t2_busycyc", 32'(busy_cnt - b0), 32'd10);
        check("t2_mem003",  32'(mem[12'h003]), 32'h1003);
        check("t2_mem103",  32'(mem[12'h103]), 32'h2003);

        // m0 alone, then contention again: round-robin now favours m1
        m_write(0, 22'h000010, 8'd0, 16'h3000);
        g0 = gn;
        fork
            m_write(0, 22'h000020, 8'd0, 16'h4000);
            m_write(1, 22'h000120, 8'd0, 16'h4100);
        join
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        first_b = 2'b01; second_b = 2'b10;
`else
        first_b = 2'b10; second_b = 2'b01;
`endif
        check("t2b_first",  32'(gseq[g0]), 32'(first_b));
        check("t2b_second", 32'(gseq[g0+1]), 32'(second_b));
        check("t2b_mem020", 32'(mem[12'h020]), 32'h4000);
        check("t2b_mem120", 32'(mem[12'h120]), 32'h4100);

        // full-page write by m1 with a stalling slave
        wmode = 1'b1;
        w0  = wbeats;
        v_0 = v0;
        m_write(1, 22'h000200, 8'd255, 16'hA000);
        wmode = 1'b0;
        check("t3_beats",   32'(wbeats - w0), 32'd256);
        check("t3_m0_quiet", 32'(v0 - v_0), 32'd0);
        check("t3_mem200",  32'(mem[12'h200]), 32'hA000);
        check("t3_mem2ff",  32'(mem[12'h2FF]), 32'hA0FF);
        check("t3_awaddr",  32'(rec_awaddr), 32'h000200);
        check("t3_awlen",   32'(rec_awlen), 32'd255);
        check("t3_busy",    32'(busy), 32'd0);

        // m0 write and read requested together: write must finish first
        fork
            m_write(0, 22'h000300, 8'd1, 16'h5555);
            m_read(0, 22'h000300, 8'd0);
        join
        check("t4_ar_after_w", 32'(ar_cyc > lastw_cyc), 32'd1);
        check("t4_rdata",      32'(rd_buf[0][0]), 32'h5555);
        check("t4_mem301",     32'(mem[12'h301]), 32'h5556);

        // reset in the middle of a 16-beat read
        @(posedge clk); #1;
        m_araddr[0] = 22'h000000; m_arlen[0] = 8'd15; m_arvalid[0] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!m_arready[0] && t < TMO);
        check("t5_ar_hs", 32'(m_arready[0]), 32'd1);
        @(posedge clk); #1;
        m_arvalid[0] = 1'b0;
        m_rready[0]  = 1'b1;
        nb = 0;
        t  = 0;
        while (nb < 5 && t < TMO) begin
            @(negedge clk);
            t++;
            if (m_rvalid[0]) begin
                @(posedge clk); #1;
                nb++;
            end
        end
        @(negedge clk);
        check("t5_beat5_pending", 32'(m_rvalid[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_grant",   32'(grant), 32'd0);
        check("t5_busy",    32'(busy), 32'd0);
        check("t5_rvalid0", 32'(m_rvalid[0]), 32'd0);
        check("t5_rready",  32'(s_rready), 32'd0);
        check("t5_arvalid", 32'(s_arvalid), 32'd0);
        check("t5_araddr",  32'(s_araddr), 32'd0);
        check("t5_wvalid",  32'(s_wvalid), 32'd0);
        $display("reset asserted after %0d read beats", nb);
        m_rready[0] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        m_read(1, 22'h0002FC, 8'd3);
        check("t5_r1_b0", 32'(rd_buf[1][0]), 32'hA0FC);
        check("t5_r1_b1", 32'(rd_buf[1][1]), 32'hA0FD);
        check("t5_r1_b2", 32'(rd_buf[1][2]), 32'hA0FE);
        check("t5_r1_b3", 32'(rd_buf[1][3]), 32'hA0FF);
        check("t5_araddr_rec", 32'(rec_araddr), 32'h0002FC);
        check("t5_end_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sdram_axi_arbiter.md
# sdram_axi_arbiter

Two-master AXI arbiter in front of the single AXI slave port of the `sdram` controller. It grants one complete transaction at a time, with round-robin fairness between masters: an address handshake plus all of its data beats. Beats are counted from `awlen`/`arlen`, so no `wlast`/`rlast` is needed. It sits between the fabric masters (e.g. CPU port and DMA/video port) and `sdram`.

## Interface
- `AW`, 22: address width; matches `sdram` `axi_awaddr`/`axi_araddr`.
- `DW`, 16: data width.
- `LW`, 8: burst length field width.
- `clk`  in  1  single clock, shared with `sdram`.
- `reset`  in  1  asynchronous, active-high.
- `m0_axi_awaddr`/`m1_axi_awaddr`, `*_axi_araddr`  in  AW  master addresses.
- `m{0,1}_axi_awlen`, `m{0,1}_axi_arlen`  in  LW  beats minus one.
- `m{0,1}_axi_awsize`, `m{0,1}_axi_arsize` (3), `m{0,1}_axi_awburst`, `m{0,1}_axi_arburst` (2)  in  passed through unchanged.
- `m{0,1}_axi_awvalid`, `m{0,1}_axi_arvalid`, `m{0,1}_axi_wvalid`, `m{0,1}_axi_rready`  in  1  master handshakes.
- `m{0,1}_axi_wdata`  in  DW; `m{0,1}_axi_wstrb`  in  DW/8.
- `m{0,1}_axi_awready`, `m{0,1}_axi_arready`, `m{0,1}_axi_wready`, `m{0,1}_axi_rvalid`  out  1  master handshakes.
- `m{0,1}_axi_rdata`  out  DW  read data; driven from `s_axi_rdata` to both masters.
- `s_axi_aw*`, `s_axi_ar*`, `s_axi_wdata`, `s_axi_wstrb`, `s_axi_wvalid`, `s_axi_rready`  out  slave side to `sdram`.
- `s_axi_awready`, `s_axi_arready`, `s_axi_wready`, `s_axi_rvalid`, `s_axi_rdata`  in  from `sdram`.
- `grant`  out  2  one-hot owner; 2'b00 when idle.
- `busy`  out  1  high in any state but IDLE.

## Operation
- States:
  - IDLE: no grant.
  - WA: write address phase.
  - WD: write data phase.
  - RA: read address phase.
  - RD: read data phase.
- Request of master k is `mk_axi_awvalid | mk_axi_arvalid`.
- IDLE, one request: grant that master.
- IDLE, both request: grant the master selected by the 1-bit pointer `ptr`.
- Granted master with both awvalid and arvalid: write wins (IDLE->WA). Otherwise IDLE->RA.
- Datapath: while granted, the owner's channel signals are muxed combinationally to the slave, and the slave's ready/valid are routed back to the owner only.
- All handshake outputs of the non-owner are 0. Slave-side valids are 0 in IDLE.
- WA:
  - Forward aw only; w and ar are gated off.
  - On `s_axi_awvalid & s_axi_awready`: capture `cnt <= awlen`, go to WD.
- WD:
  - Forward w only.
  - Each `s_axi_wvalid & s_axi_wready` with `cnt != 0` decrements `cnt`.
  - The beat with `cnt == 0` ends the transaction: go to IDLE, set `ptr <= ~owner`.
- RA/RD: same as WA/WD using ar, arlen, `s_axi_rvalid & s_axi_rready`.
- Widths and limits:
  - `cnt` is LW bits.
  - awlen=255 gives 256 beats (a full `sdram` page).
  - No wrap past 0.
- A master dropping valid mid-burst just stalls; there is no timeout and no abort.
- Reset (any time, including mid-burst):
  - All outputs go to 0, state IDLE, `ptr=0`, `cnt=0`.
  - The burst in progress is discarded.
  - `sdram` must be reset by the same `reset`.

## Timing
- Grant decision is registered. A request sampled in IDLE at edge n gives `grant`, `busy` and slave valid at n+1, combinationally the same cycle as the state change.
- Address, data and ready paths have zero added latency (combinational mux).
- At least one IDLE cycle follows every transaction, so back-to-back transactions have a 1-cycle gap.
- Write of N beats with an always-ready slave: 1 (arb) + 1 (aw) + N cycles.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN`:
  - Defined: `ptr` is held at 0, so m0 always wins when both masters request (low-latency CPU port). m1 can starve.
  - Undefined: round-robin as above.

## Test plan
- Reset, then m0 writes awaddr=0x000000, awlen=0, wdata=0x1234; m0 reads back addr 0, arlen=0 -> `rdata`=0x1234; `grant`=01 during each transaction, 00 between.
- m0 and m1 assert awvalid in the same cycle (m0 addr 0x000000, m1 addr 0x000100, awlen=3) -> m0 granted first, m1 second, `ptr` alternates. With `SDRAM_ARB_FIXED_PRIO_EN` and m0 re-requesting continuously -> m0 always granted.
- m1 write awlen=255 with the slave deasserting wready every 3rd cycle -> exactly 256 beats forwarded, then IDLE; m0 ready stays 0 throughout.
- m0 asserts awvalid and arvalid together -> write completes fully before the read address is forwarded.
- Assert `reset` at beat 5 of a 16-beat read -> all outputs 0 the same cycle. After release, a fresh m1 read of 4 beats completes correctly.
